bus_memory_responder: RTL and testbench
=======================================

Name: bus_memory_responder

Overview:
- Word-addressed 64 x 8 memory that answers the adding-machine datapath's bus requests.
- Inputs from the datapath:
  - 6-bit address, selected from IR[5:0] or PC by the datapath's address mux.
  - Write data, taken from the datapath's ALU/Data_bus_out.
- Returns read data to the datapath's Data_bus_in.
- Provides a one-cycle ready handshake with a configurable number of wait states, so the control FSM can sequence fetch/execute against a realistic memory.

Parameters:
- ADDR_W, 6, address width; depth = 2**ADDR_W words.
- DATA_W, 8, word width.
- WAIT_STATES, 1, extra busy cycles before completion (0..15).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  ADDR_W  word address of the request.
- data_in  input  DATA_W  write data, driven by the datapath's Data_bus_out.
- rd_mem  input  1  read request, level-sensitive.
- wr_mem  input  1  write request, level-sensitive.
- data_out  output  DATA_W  read data to the datapath's Data_bus_in.
- mem_ready  output  1  transaction-complete pulse, exactly one cycle.
- busy  output  1  high while a transaction is in progress (BUSY or DONE state).

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; wait counter = 0.
  - data_out = 0, mem_ready = 0, busy = 0.
  - All 64 words cleared to 0x00.
  - Reset asserted mid-transaction aborts it; a pending write is not committed.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If wr_mem = 1, or rd_mem = 1, on a rising edge:
    - Capture address, data_in and the operation into internal registers.
    - Load the wait counter with WAIT_STATES.
    - Go to BUSY if WAIT_STATES > 0, else go directly to DONE.
  - If rd_mem and wr_mem are both 1, the write wins; the read is dropped.
  - Otherwise stay in IDLE.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to DONE on the next edge.
  - rd_mem, wr_mem, address and data_in are ignored; the captured values are used.
- DONE (exactly one cycle):
  - mem_ready = 1.
  - Write: mem[captured address] <= captured data on the edge entering DONE; data_out is unchanged.
  - Read: data_out <= mem[captured address] on the edge entering DONE.
  - Next state is always IDLE.
- Latency: mem_ready is asserted WAIT_STATES+1 cycles after the edge that sampled the request.
- Handshake:
  - Requests are level-sensitive.
  - The requester must deassert rd_mem/wr_mem in the cycle mem_ready = 1.
  - A strobe still high in IDLE after DONE starts a new transaction; this gives back-to-back throughput of one transaction per WAIT_STATES+2 cycles.
- data_out holds the last read value until the next read completes; writes and idle cycles never change it.
- Read-after-write to the same address returns the new value.
- Address is taken as-is, ADDR_W bits, with no wrap logic; for a 6-bit address every value 0..63 is valid.
- busy = 1 in BUSY and DONE, 0 in IDLE.

Optional Feature:
- Macro: MEM_WRITE_PROTECT_EN.
- When defined:
  - Extra parameter PROTECT_BASE, default 48.
  - Extra output wr_fault (1 bit).
  - Writes to addresses >= PROTECT_BASE complete normally (same latency, mem_ready pulses) but memory is not modified.
  - wr_fault goes to 1 in that DONE cycle and stays high until reset.
- When undefined:
  - No wr_fault port.
  - All addresses are writable.

Test Plan:
- Reset clears: assert reset mid-cycle with no clock edge. Required: data_out = 0, busy = 0 immediately. Then read addr 0x15 -> data_out = 0x00.
- Write then read, WAIT_STATES = 1: write 0xA5 to 0x2A, then read 0x2A. Required: mem_ready exactly 2 cycles after each request edge, and data_out = 0xA5.
- Simultaneous rd_mem and wr_mem: write 0x3C to 0x07 with both strobes high. Required: memory[0x07] = 0x3C and data_out keeps its previous value.
- Inputs ignored during BUSY, WAIT_STATES = 3: change address and data_in while BUSY. Required: write lands at the originally captured address, and mem_ready arrives 4 cycles after the request edge.
- Reset mid-write: assert reset during BUSY of a write of 0xFF to 0x10. Required: state returns to IDLE, and a later read of 0x10 returns 0x00.
- Write protect, with MEM_WRITE_PROTECT_EN defined: write 0x55 to 0x30. Required: mem_ready pulses, wr_fault = 1, and a later read of 0x30 returns 0x00. A write of 0x55 to 0x2F succeeds.

Source files
------------

// File: rtl/bus_memory_responder.sv
// Word-addressed memory responder with a ready handshake and configurable wait states.
// Optional write protection of the upper address range: define MEM_WRITE_PROTECT_EN.
module bus_memory_responder #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 1
`ifdef MEM_WRITE_PROTECT_EN
    ,
    parameter int unsigned PROTECT_BASE = 48
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_mem,
    input  logic              wr_mem,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_ready,
    output logic              busy
`ifdef MEM_WRITE_PROTECT_EN
    ,
    output logic              wr_fault
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [3:0]  WS_L  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              commit;
    logic              wr_allow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        case (state_q)
            S_IDLE: begin
                if (wr_mem || rd_mem) begin
                    addr_d  = address;
                    wdata_d = data_in;
                    is_wr_d = wr_mem;
                    cnt_d   = WS_L;
                    state_d = (WAIT_STATES > 0) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory and read data update on the edge entering DONE; the _d values
    // cover the zero-wait case where capture and completion share one edge.
    assign commit = (state_d == S_DONE) && (state_q != S_DONE);

`ifdef MEM_WRITE_PROTECT_EN
    localparam logic [ADDR_W:0] PB_L = (ADDR_W + 1)'(PROTECT_BASE);
    logic wr_fault_q;

    assign wr_allow = ({1'b0, addr_d} < PB_L);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                               wr_fault_q <= 1'b0;
        else if (commit && is_wr_d && !wr_allow) wr_fault_q <= 1'b1;
    end

    assign wr_fault = wr_fault_q;
`else
    assign wr_allow = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (commit && is_wr_d && wr_allow) begin
            mem_q[addr_d] <= wdata_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                   rdata_q <= '0;
        else if (commit && !is_wr_d) rdata_q <= mem_q[addr_d];
    end

    assign data_out  = rdata_q;
    assign mem_ready = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed scoreboard bench: three responders with 1, 3 and 0 wait states.
// Exercises write protection as well when MEM_WRITE_PROTECT_EN is defined.
module tb_bus_memory_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] addr [3];
    logic [7:0] din  [3];
    logic       rd   [3];
    logic       wr   [3];
    logic [7:0] dout [3];
    logic       rdy  [3];
    logic       bsy  [3];
`ifdef MEM_WRITE_PROTECT_EN
    logic       flt  [3];
`endif

    int         tests = 0;
    int         fails = 0;
    int         ws_of [3] = '{1, 3, 0};
    logic [7:0] model [3][64];
    logic [7:0] rd_q  [$];

    always #5 clk = ~clk;

    bus_memory_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_STATES(1)) u0 (
        .clock(clk), .reset(rst), .address(addr[0]), .data_in(din[0]),
        .rd_mem(rd[0]), .wr_mem(wr[0]), .data_out(dout[0]),
        .mem_ready(rdy[0]), .busy(bsy[0])
`ifdef MEM_WRITE_PROTECT_EN
        , .wr_fault(flt[0])
`endif
    );

    bus_memory_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_STATES(3)) u1 (
        .clock(clk), .reset(rst), .address(addr[1]), .data_in(din[1]),
        .rd_mem(rd[1]), .wr_mem(wr[1]), .data_out(dout[1]),
        .mem_ready(rdy[1]), .busy(bsy[1])
`ifdef MEM_WRITE_PROTECT_EN
        , .wr_fault(flt[1])
`endif
    );

    bus_memory_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_STATES(0)) u2 (
        .clock(clk), .reset(rst), .address(addr[2]), .data_in(din[2]),
        .rd_mem(rd[2]), .wr_mem(wr[2]), .data_out(dout[2]),
        .mem_ready(rdy[2]), .busy(bsy[2])
`ifdef MEM_WRITE_PROTECT_EN
        , .wr_fault(flt[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 64; a++) model[s][a] = 8'h00;
    endtask

    function automatic bit protected_addr(input logic [5:0] a);
`ifdef MEM_WRITE_PROTECT_EN
        return (a >= 6'd48);
`else
        return 1'b0;
`endif
    endfunction

    // One level-sensitive transaction; strobes drop in the mem_ready cycle.
    task automatic txn(input string tag, input int s, input logic w, input logic r,
                       input logic [5:0] a, input logic [7:0] d, input logic disturb);
        int         lat;
        bit         seen;
        logic [7:0] prev;
        logic [7:0] exp_d;
        @(negedge clk);
        prev = dout[s];
        addr[s] = a; din[s] = d; wr[s] = w; rd[s] = r;
        if (r && !w) rd_q.push_back(model[s][a]);
        @(posedge clk);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rdy[s]) seen = 1'b1;
            else if (disturb) begin addr[s] = ~a; din[s] = ~d; end
        end
        wr[s] = 1'b0; rd[s] = 1'b0;
        check({tag, "_latency"}, seen ? lat : -1, ws_of[s] + 1);
        if (seen) begin
            check({tag, "_busy_done"}, bsy[s], 1'b1);
            if (w) begin
                if (!protected_addr(a)) model[s][a] = d;
                check({tag, "_dout_hold"}, dout[s], prev);
            end else begin
                exp_d = 8'hxx;
                if (rd_q.size() > 0) exp_d = rd_q.pop_front();
                check({tag, "_rdata"}, dout[s], exp_d);
            end
            @(negedge clk);
            check({tag, "_ready_pulse"}, rdy[s], 1'b0);
            check({tag, "_idle"}, bsy[s], 1'b0);
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            addr[s] = '0; din[s] = '0; rd[s] = 1'b0; wr[s] = 1'b0;
        end
        clear_model();
        #1;
        for (int s = 0; s < 3; s++) begin
            check("reset_dout", dout[s], 8'h00);
            check("reset_busy", bsy[s], 1'b0);
            check("reset_ready", rdy[s], 1'b0);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // WAIT_STATES = 1
        txn("rd15", 0, 1'b0, 1'b1, 6'h15, 8'h00, 1'b0);
        txn("wr2A", 0, 1'b1, 1'b0, 6'h2A, 8'hA5, 1'b0);
        txn("rd2A", 0, 1'b0, 1'b1, 6'h2A, 8'h00, 1'b0);
        txn("both07", 0, 1'b1, 1'b1, 6'h07, 8'h3C, 1'b0);
        txn("rd07", 0, 1'b0, 1'b1, 6'h07, 8'h00, 1'b0);

        // WAIT_STATES = 3, inputs disturbed while busy
        txn("wr05_dist", 1, 1'b1, 1'b0, 6'h05, 8'h77, 1'b1);
        txn("rd3A", 1, 1'b0, 1'b1, 6'h3A, 8'h00, 1'b0);
        txn("rd05", 1, 1'b0, 1'b1, 6'h05, 8'h00, 1'b0);

        // WAIT_STATES = 0, top address
        txn("wr3F", 2, 1'b1, 1'b0, 6'h3F, 8'hC3, 1'b0);
        txn("rd3F", 2, 1'b0, 1'b1, 6'h3F, 8'h00, 1'b0);
        txn("wr00", 2, 1'b1, 1'b0, 6'h00, 8'h5A, 1'b0);
        txn("rd00", 2, 1'b0, 1'b1, 6'h00, 8'h00, 1'b0);

        // Reset during BUSY of a write
        @(negedge clk);
        addr[1] = 6'h10; din[1] = 8'hFF; wr[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midwr_busy", bsy[1], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midwr_rst_busy", bsy[1], 1'b0);
        check("midwr_rst_ready", rdy[1], 1'b0);
        check("midwr_rst_dout1", dout[1], 8'h00);
        check("midwr_rst_dout0", dout[0], 8'h00);
        wr[1] = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        txn("rd10_after_rst", 1, 1'b0, 1'b1, 6'h10, 8'h00, 1'b0);
        txn("rd2A_after_rst", 0, 1'b0, 1'b1, 6'h2A, 8'h00, 1'b0);
        txn("rd15_after_rst", 0, 1'b0, 1'b1, 6'h15, 8'h00, 1'b0);

`ifdef MEM_WRITE_PROTECT_EN
        check("fault_init", flt[0], 1'b0);
        txn("wr2F", 0, 1'b1, 1'b0, 6'h2F, 8'h55, 1'b0);
        check("fault_after_2F", flt[0], 1'b0);
        txn("wr30", 0, 1'b1, 1'b0, 6'h30, 8'h55, 1'b0);
        check("fault_after_30", flt[0], 1'b1);
        txn("rd30", 0, 1'b0, 1'b1, 6'h30, 8'h00, 1'b0);
        txn("rd2F", 0, 1'b0, 1'b1, 6'h2F, 8'h00, 1'b0);
        check("fault_sticky", flt[0], 1'b1);
`endif

        check("scoreboard_empty", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
